// File: rtl/bus_arbiter.sv
// bus_arbiter -- round-robin arbiter for a 4-master shared bus.
//
// Picks one owner among four masters with active-low requests and drives
// one-hot active-low grants decoded from the registered owner index. The
// owner keeps the bus until it drops its request. With MAX_HOLD != 0 a
// continuously requesting owner is moved on once it has held the bus for
// MAX_HOLD cycles, but only on a cycle where its address strobe is idle.
//
// Ports:
//   clk              system clock, rising edge
//   reset_           asynchronous active-low reset (owner -> 0)
//   mN_req_          master N bus request, active-low
//   mN_as_           master N address strobe, active-low (preemption gate only)
//   mN_grnt_         master N grant, active-low, exactly one low at all times
//   owner            index of the current bus owner
module bus_arbiter #(
  parameter int unsigned MAX_HOLD = 0,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       m0_req_,
  input  logic       m0_as_,
  input  logic       m1_req_,
  input  logic       m1_as_,
  input  logic       m2_req_,
  input  logic       m2_as_,
  input  logic       m3_req_,
  input  logic       m3_as_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner
);

  logic [3:0]        req_n;
  logic [3:0]        as_n;
  logic [1:0]        owner_q, owner_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]        next_idx;
  logic [1:0]        cand;
  logic              found;
  logic              owner_req;
  logic              owner_as_idle;
  logic              at_limit;

  assign req_n = {m3_req_, m2_req_, m1_req_, m0_req_};
  assign as_n  = {m3_as_, m2_as_, m1_as_, m0_as_};

  // State register
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      owner_q    <= '0;
      hold_cnt_q <= '0;
    end else begin
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Rotating search starting just after the owner; the owner is never a candidate.
  always_comb begin
    found    = 1'b0;
    next_idx = owner_q;
    cand     = owner_q;
    for (int unsigned i = 1; i < 4; i++) begin
      cand = owner_q + 2'(i);
      if (!found && !req_n[cand]) begin
        found    = 1'b1;
        next_idx = cand;
      end
    end
  end

  // Next-state: release, then preempt, then hold
  always_comb begin
    owner_req     = ~req_n[owner_q];
    owner_as_idle = as_n[owner_q];
    at_limit      = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_W'(MAX_HOLD));
    owner_d       = owner_q;
    hold_cnt_d    = '0;
    if (!owner_req) begin
      // Released: hand over if anyone waits, otherwise park on this owner.
      if (found) owner_d = next_idx;
    end else if (at_limit && owner_as_idle && found) begin
      owner_d = next_idx;
    end else if (hold_cnt_q != HOLD_W'(MAX_HOLD)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end else begin
      // Saturated: stay at the limit so preemption fires on the first idle strobe.
      hold_cnt_d = hold_cnt_q;
    end
  end

  // Outputs decoded from the registered owner only
  always_comb begin
    {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = ~(4'b0001 << owner_q);
    owner = owner_q;
  end

endmodule
